hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage core.

- Decides per cycle which pipeline registers hold (stall) and which load a bubble.
- Detects load-use hazards that the operand-forwarding unit cannot cover.
- Sequences multi-cycle MDU (mul/div) operations in EX.
- Arbitrates branch redirects against memory wait states.
- Tracks wrong-path instruction fetches that are still in flight.

---
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: stall/bubble decisions, load-use
// detection, multi-cycle MDU sequencing and wrong-path fetch drop tracking.
module hazard_ctrl #(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       id_valid,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_is_mdu,
  input  logic       ex_redirect,
  input  logic       imem_busy,
  input  logic       imem_resp_valid,
  input  logic       dmem_busy,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       bubble_id,
  output logic       bubble_ex,
  output logic       bubble_mem,
  output logic       redirect_fire,
  output logic       drop_fetch,
  output logic       mdu_busy,
  output logic       mdu_done
);

  localparam int unsigned CNT_W = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 2);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  mdu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             flush_pending, flush_next;

  logic load_use;
  logic mdu_stall;
  logic fetch_wait;

  // Load-use on a non-zero destination cannot be covered by forwarding.
  assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  assign mdu_stall  = ((state == IDLE) & ex_valid & ex_is_mdu) |
                      ((state == BUSY) & (cnt != '0));
  assign mdu_busy   = mdu_stall;
  assign mdu_done   = (state == BUSY) & (cnt == '0);
  assign fetch_wait = imem_busy & ~imem_resp_valid;
  assign drop_fetch = flush_pending & imem_resp_valid;

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      flush_pending <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      flush_pending <= flush_next;
    end
  end

  // MDU sequencer; a data-memory wait freezes it in place.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!dmem_busy) begin
      case (state)
        IDLE: begin
          if (ex_valid && ex_is_mdu) begin
            state_next = BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt != '0) cnt_next = cnt - CNT_W'(1);
          else           state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A returning response always clears the flag, so clear beats set.
  always_comb begin
    flush_next = flush_pending;
    if (imem_resp_valid)                 flush_next = 1'b0;
    else if (redirect_fire && imem_busy) flush_next = 1'b1;
  end

  // Prioritised stall / bubble / redirect decision.
  always_comb begin
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    stall_ex      = 1'b0;
    stall_mem     = 1'b0;
    bubble_id     = 1'b0;
    bubble_ex     = 1'b0;
    bubble_mem    = 1'b0;
    redirect_fire = 1'b0;
    if (dmem_busy) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else if (mdu_stall) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      stall_ex   = 1'b1;
      bubble_mem = 1'b1;
    end else if (ex_valid && ex_redirect) begin
      redirect_fire = 1'b1;
      bubble_id     = 1'b1;
      bubble_ex     = 1'b1;
      stall_if      = fetch_wait;
    end else if (load_use) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (fetch_wait || drop_fetch) begin
      stall_if  = 1'b1;
      bubble_id = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives inputs after a rising edge
// and compares all outputs against a hand-computed vector mid-cycle.
module tb_hazard_ctrl;

  localparam logic [10:0] S_IF  = 11'h400;
  localparam logic [10:0] S_ID  = 11'h200;
  localparam logic [10:0] S_EX  = 11'h100;
  localparam logic [10:0] S_MEM = 11'h080;
  localparam logic [10:0] B_ID  = 11'h040;
  localparam logic [10:0] B_EX  = 11'h020;
  localparam logic [10:0] B_MEM = 11'h010;
  localparam logic [10:0] RF    = 11'h008;
  localparam logic [10:0] DROP  = 11'h004;
  localparam logic [10:0] MBUSY = 11'h002;
  localparam logic [10:0] MDONE = 11'h001;
  localparam logic [10:0] NONE  = 11'h000;
  localparam logic [10:0] MDU_STALL = S_IF | S_ID | S_EX | B_MEM | MBUSY;
  localparam logic [10:0] ALL_STALL = S_IF | S_ID | S_EX | S_MEM;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, id_valid, ex_valid;
  logic       ex_is_load, ex_is_mdu, ex_redirect;
  logic       imem_busy, imem_resp_valid, dmem_busy;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       bubble_id, bubble_ex, bubble_mem;
  logic       redirect_fire, drop_fetch, mdu_busy, mdu_done;
  logic [10:0] obs;

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl #(.MDU_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_valid(id_valid), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_is_mdu(ex_is_mdu), .ex_redirect(ex_redirect),
    .imem_busy(imem_busy), .imem_resp_valid(imem_resp_valid), .dmem_busy(dmem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .bubble_id(bubble_id), .bubble_ex(bubble_ex), .bubble_mem(bubble_mem),
    .redirect_fire(redirect_fire), .drop_fetch(drop_fetch),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done)
  );

  always #5 clk = ~clk;

  assign obs = {stall_if, stall_id, stall_ex, stall_mem, bubble_id, bubble_ex,
                bubble_mem, redirect_fire, drop_fetch, mdu_busy, mdu_done};

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_valid = 1'b0; ex_valid = 1'b0;
    ex_is_load = 1'b0; ex_is_mdu = 1'b0; ex_redirect = 1'b0;
    imem_busy = 1'b0; imem_resp_valid = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [10:0] exp);
    #2;
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic load_use_setup(input logic [4:0] rd, input logic [4:0] rs1);
    idle();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd;
    id_valid = 1'b1; id_rs1 = rs1; id_uses_rs1 = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1 check("reset_held", NONE);
    next_cycle();
    reset = 1'b0;
    check("post_reset_idle", NONE);

    // Load-use: one bubble, then the load sits in MEM.
    next_cycle(); load_use_setup(5'd5, 5'd5);
    check("load_use_rs1", S_IF | S_ID | B_EX);
    next_cycle(); idle(); ex_valid = 1'b1; ex_rd = 5'd7; id_valid = 1'b1;
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    check("load_use_after", NONE);
    next_cycle(); load_use_setup(5'd0, 5'd0);
    check("load_use_x0", NONE);
    next_cycle(); load_use_setup(5'd9, 5'd1); id_uses_rs2 = 1'b1; id_rs2 = 5'd9;
    check("load_use_rs2", S_IF | S_ID | B_EX);
    next_cycle(); load_use_setup(5'd9, 5'd9); id_uses_rs1 = 1'b0;
    check("load_use_unused", NONE);
    next_cycle(); load_use_setup(5'd6, 5'd6); imem_busy = 1'b1;
    check("load_use_imem_busy", S_IF | S_ID | B_EX);

    // MDU, no memory waits: three stall cycles then done.
    next_cycle(); idle(); ex_valid = 1'b1; ex_is_mdu = 1'b1;
    check("mdu_c1", MDU_STALL);
    next_cycle(); check("mdu_c2", MDU_STALL);
    next_cycle(); check("mdu_c3", MDU_STALL);
    next_cycle(); check("mdu_c4_done", MDONE);
    next_cycle(); idle();
    check("mdu_back_idle", NONE);

    // MDU with two dmem_busy cycles in the middle: six cycles total.
    next_cycle(); ex_valid = 1'b1; ex_is_mdu = 1'b1;
    check("mdu_w_c1", MDU_STALL);
    next_cycle(); dmem_busy = 1'b1;
    check("mdu_w_c2_dmem", ALL_STALL | MBUSY);
    next_cycle(); check("mdu_w_c3_dmem", ALL_STALL | MBUSY);
    next_cycle(); dmem_busy = 1'b0;
    check("mdu_w_c4", MDU_STALL);
    next_cycle(); check("mdu_w_c5", MDU_STALL);
    next_cycle(); check("mdu_w_c6_done", MDONE);
    next_cycle(); idle();
    check("mdu_w_back_idle", NONE);

    // Redirect with a fetch outstanding: one drop on the response.
    next_cycle(); ex_valid = 1'b1; ex_redirect = 1'b1; imem_busy = 1'b1;
    check("redir_fire", RF | B_ID | B_EX | S_IF);
    next_cycle(); idle(); imem_busy = 1'b1;
    check("redir_wait1", S_IF | B_ID);
    next_cycle(); check("redir_wait2", S_IF | B_ID);
    next_cycle(); imem_resp_valid = 1'b1;
    check("redir_drop", DROP | S_IF | B_ID);
    next_cycle(); idle();
    check("redir_cleared", NONE);
    next_cycle(); imem_resp_valid = 1'b1;
    check("resp_no_drop", NONE);

    // Redirect without an outstanding fetch leaves nothing to drop.
    next_cycle(); idle(); ex_valid = 1'b1; ex_redirect = 1'b1;
    check("redir_no_fetch", RF | B_ID | B_EX);
    next_cycle(); idle(); imem_resp_valid = 1'b1;
    check("redir_no_fetch_resp", NONE);
    next_cycle(); idle(); ex_redirect = 1'b1;
    check("redir_invalid_ex", NONE);

    // Conflicts.
    next_cycle(); idle(); ex_valid = 1'b1; ex_redirect = 1'b1; dmem_busy = 1'b1;
    check("redir_vs_dmem", ALL_STALL);
    next_cycle(); load_use_setup(5'd5, 5'd5); ex_redirect = 1'b1;
    check("redir_vs_load_use", RF | B_ID | B_EX);

    // Reset in the middle of an MDU sequence (cnt == 1).
    next_cycle(); idle(); ex_valid = 1'b1; ex_is_mdu = 1'b1;
    check("rst_mdu_c1", MDU_STALL);
    next_cycle(); check("rst_mdu_c2", MDU_STALL);
    next_cycle(); check("rst_mdu_c3", MDU_STALL);
    idle(); reset = 1'b1;
    check("rst_mdu_abort", NONE);
    next_cycle(); reset = 1'b0;
    check("rst_mdu_no_done", NONE);
    next_cycle(); check("rst_mdu_idle", NONE);

    // Reset while a flush is pending: the later response is not dropped.
    next_cycle(); ex_valid = 1'b1; ex_redirect = 1'b1; imem_busy = 1'b1;
    check("rst_flush_fire", RF | B_ID | B_EX | S_IF);
    next_cycle(); idle(); reset = 1'b1;
    check("rst_flush_held", NONE);
    next_cycle(); reset = 1'b0; imem_resp_valid = 1'b1;
    check("rst_flush_no_drop", NONE);

    next_cycle(); idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
